// File: rtl/pe_sched_pkg.sv
// Shared definitions for the PE array scheduler.
//   state_t   : sequencer states
//   FRAME_LEN : cycles per array frame (phase counter period)
//   N_WEIGHT  : weight words per frame, replayed at phases 0..N_WEIGHT-1
//   ACT_PH0   : first activation phase of a frame
//   DATA_W    : width of the array data_in bus
package pe_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        ALIGN,
        RUN,
        DRAIN
    } state_t;

    localparam int FRAME_LEN = 12;
    localparam int N_WEIGHT  = 9;
    localparam int ACT_PH0   = 9;
    localparam int DATA_W    = 27;

endpackage

// File: rtl/pe_array_sched_phase.sv
// Free-running frame phase counter, mirror of the PE array's own counter.
// Counts 0..FRAME_LEN-1 from reset and is never gated, so it stays aligned
// with the array as long as both share the same reset.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-low reset
//   phase          : current frame phase
//   frame_last     : phase is the last of the frame
//   wt_slot        : phase carries a weight word
//   act_rd_slot    : phase at which an activation read is issued
//   cap_slot[r]    : phase at which psum row r is valid
module pe_phase_ctr
    import pe_sched_pkg::*;
#(
    parameter int CAP_PHASE = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    output logic [3:0] phase,
    output logic       frame_last,
    output logic       wt_slot,
    output logic       act_rd_slot,
    output logic [2:0] cap_slot
);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            phase <= '0;
        end else if (phase == 4'(FRAME_LEN - 1)) begin
            phase <= '0;
        end else begin
            phase <= phase + 4'd1;
        end
    end

    always_comb begin
        frame_last  = (phase == 4'(FRAME_LEN - 1));
        wt_slot     = (phase < 4'(N_WEIGHT));
        // Reads go out one cycle ahead of the activation slots.
        act_rd_slot = (phase >= 4'(ACT_PH0 - 1)) && (phase <= 4'(FRAME_LEN - 2));
        for (int unsigned r = 0; r < 3; r++) begin
            cap_slot[r] = (phase == 4'(CAP_PHASE + int'(r)));
        end
    end

endmodule

// File: rtl/pe_array_sched.sv
// Phase-locked sequencer for a 3x3 weight-stationary PE array.
// Loads 9 weight words into a local cache, then replays them every frame
// together with 3 streamed activation words, and returns one 3-bit sign
// result per frame from the array's row partial sums.
// Optional build macro: PE_SCHED_FULL_PSUM_EN adds res_psum_out.
// Ports:
//   clk_in, rst_in          : clock, asynchronous active-low reset
//   start_in                : job start pulse (ignored while busy)
//   num_frames_in           : frames in job, sampled at start
//   act_base_in             : first activation address, sampled at start
//   busy_out, done_out      : job status / end-of-job pulse
//   wmem_rd_out/addr/rdata  : weight SRAM, 1-cycle read latency
//   amem_rd_out/addr/rdata  : activation SRAM, 1-cycle read latency
//   pe_data_out             : array data_in bus
//   psum_row_{0,1,2}_in     : array row partial sums
//   res_valid_out/res_bits  : result strobe, {row2,row1,row0} sign bits
//   res_psum_out            : (optional) full captured psums
module pe_array_sched
    import pe_sched_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int ADDR_W    = 12,
    parameter int CAP_PHASE = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                start_in,
    input  logic [15:0]         num_frames_in,
    input  logic [ADDR_W-1:0]   act_base_in,
    output logic                busy_out,
    output logic                done_out,
    output logic                wmem_rd_out,
    output logic [3:0]          wmem_addr_out,
    input  logic [DATA_W-1:0]   wmem_rdata_in,
    output logic                amem_rd_out,
    output logic [ADDR_W-1:0]   amem_addr_out,
    input  logic [DATA_W-1:0]   amem_rdata_in,
    output logic [DATA_W-1:0]   pe_data_out,
    input  logic [WIDTH-1:0]    psum_row_0_in,
    input  logic [WIDTH-1:0]    psum_row_1_in,
    input  logic [WIDTH-1:0]    psum_row_2_in,
`ifdef PE_SCHED_FULL_PSUM_EN
    output logic [3*WIDTH-1:0]  res_psum_out,
`endif
    output logic                res_valid_out,
    output logic [2:0]          res_bits_out
);

    state_t state, state_nx;

    logic [3:0]        phase;
    logic              frame_last;
    logic              wt_slot;
    logic              act_rd_slot;
    logic [2:0]        cap_slot;

    logic [DATA_W-1:0] wcache [N_WEIGHT];
    logic [3:0]        widx;
    logic              wr_en;
    logic [3:0]        wr_idx;
    logic              act_vld;
    logic [15:0]       frames;
    logic [15:0]       fcnt;
    logic [ADDR_W-1:0] frame_addr;
    logic [2:0]        cap_sign;
    logic              start_ok;
    logic              cap_en;
    logic [WIDTH-1:0]  rows [3];

    pe_phase_ctr #(
        .CAP_PHASE(CAP_PHASE)
    ) u_phase (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .phase      (phase),
        .frame_last (frame_last),
        .wt_slot    (wt_slot),
        .act_rd_slot(act_rd_slot),
        .cap_slot   (cap_slot)
    );

    always_comb begin
        rows[0] = psum_row_0_in;
        rows[1] = psum_row_1_in;
        rows[2] = psum_row_2_in;
    end

    assign start_ok = start_in && (state == IDLE) && !busy_out;
    // Frame 0 of RUN has no valid psums yet; DRAIN carries the last frame's.
    assign cap_en   = (state == DRAIN) || ((state == RUN) && (fcnt != '0));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        wmem_rd_out   = 1'b0;
        wmem_addr_out = '0;
        amem_rd_out   = 1'b0;
        amem_addr_out = '0;
        pe_data_out   = '0;
        case (state)
            IDLE: begin
                if (start_ok && (num_frames_in != '0)) begin
                    state_nx = WLOAD;
                end
            end
            WLOAD: begin
                if (widx < 4'(N_WEIGHT)) begin
                    wmem_rd_out   = 1'b1;
                    wmem_addr_out = widx;
                end
                if (wr_en && (wr_idx == 4'(N_WEIGHT - 1))) begin
                    state_nx = ALIGN;
                end
            end
            ALIGN: begin
                if (frame_last) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (act_rd_slot) begin
                    amem_rd_out   = 1'b1;
                    amem_addr_out = frame_addr + ADDR_W'(phase - 4'(ACT_PH0 - 1));
                end
                if (frame_last && (fcnt == frames - 16'd1)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if ((state == RUN) || (state == DRAIN)) begin
            if (wt_slot) begin
                pe_data_out = wcache[phase];
            end else if (act_vld) begin
                pe_data_out = amem_rdata_in;
            end
        end
    end

    // Weight fetch and activation read tracking.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            widx    <= '0;
            wr_en   <= 1'b0;
            wr_idx  <= '0;
            act_vld <= 1'b0;
            for (int unsigned i = 0; i < N_WEIGHT; i++) begin
                wcache[i] <= '0;
            end
        end else begin
            wr_en   <= wmem_rd_out;
            wr_idx  <= widx;
            act_vld <= amem_rd_out;
            if (wr_en) begin
                wcache[wr_idx] <= wmem_rdata_in;
            end
            if (state != WLOAD) begin
                widx <= '0;
            end else if (wmem_rd_out) begin
                widx <= widx + 4'd1;
            end
        end
    end

    // Job bookkeeping.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            frames     <= '0;
            fcnt       <= '0;
            frame_addr <= '0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
        end else begin
            if (start_ok && (num_frames_in != '0)) begin
                frames     <= num_frames_in;
                fcnt       <= '0;
                frame_addr <= act_base_in;
            end else if ((state == RUN) && frame_last) begin
                fcnt       <= fcnt + 16'd1;
                frame_addr <= frame_addr + ADDR_W'(3);
            end
            done_out <= (start_ok && (num_frames_in == '0)) ||
                        ((state == DRAIN) && frame_last);
            if (start_ok && (num_frames_in != '0)) begin
                busy_out <= 1'b1;
            end else if (done_out) begin
                busy_out <= 1'b0;
            end
        end
    end

    // Result capture: row r latched at its phase, published after row 2.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cap_sign      <= '0;
            res_valid_out <= 1'b0;
            res_bits_out  <= '0;
        end else begin
            for (int unsigned r = 0; r < 3; r++) begin
                if (cap_en && cap_slot[r]) begin
                    cap_sign[r] <= rows[r][WIDTH-1];
                end
            end
            res_valid_out <= cap_en && cap_slot[2];
            if (cap_en && cap_slot[2]) begin
                res_bits_out <= {rows[2][WIDTH-1], cap_sign[1:0]};
            end
        end
    end

`ifdef PE_SCHED_FULL_PSUM_EN
    logic [WIDTH-1:0] cap_psum [2];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cap_psum[0]  <= '0;
            cap_psum[1]  <= '0;
            res_psum_out <= '0;
        end else begin
            if (cap_en && cap_slot[0]) cap_psum[0] <= rows[0];
            if (cap_en && cap_slot[1]) cap_psum[1] <= rows[1];
            if (cap_en && cap_slot[2]) begin
                res_psum_out <= {rows[2], cap_psum[1], cap_psum[0]};
            end
        end
    end
`else
    logic unused_psum_bits;
    assign unused_psum_bits = ^{psum_row_0_in[WIDTH-2:0],
                                psum_row_1_in[WIDTH-2:0],
                                psum_row_2_in[WIDTH-2:0]};
`endif

endmodule

// File: tb/tb_pe_array_sched.sv
module tb_pe_array_sched;
    import pe_sched_pkg::*;

    localparam int WIDTH     = 14;
    localparam int ADDR_W    = 12;
    localparam int CAP_PHASE = 2;

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b0;
    logic                start_in = 1'b0;
    logic [15:0]         num_frames_in = '0;
    logic [ADDR_W-1:0]   act_base_in = '0;
    logic                busy_out, done_out;
    logic                wmem_rd_out, amem_rd_out;
    logic [3:0]          wmem_addr_out;
    logic [ADDR_W-1:0]   amem_addr_out;
    logic [DATA_W-1:0]   wmem_rdata_in = '0;
    logic [DATA_W-1:0]   amem_rdata_in = '0;
    logic [DATA_W-1:0]   pe_data_out;
    logic [WIDTH-1:0]    p0 = '0, p1 = '0, p2 = '0;
    logic                res_valid_out;
    logic [2:0]          res_bits_out;
`ifdef PE_SCHED_FULL_PSUM_EN
    logic [3*WIDTH-1:0]  res_psum_out;
`endif

    pe_array_sched #(
        .WIDTH(WIDTH),
        .ADDR_W(ADDR_W),
        .CAP_PHASE(CAP_PHASE)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (start_in),
        .num_frames_in(num_frames_in),
        .act_base_in  (act_base_in),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .wmem_rd_out  (wmem_rd_out),
        .wmem_addr_out(wmem_addr_out),
        .wmem_rdata_in(wmem_rdata_in),
        .amem_rd_out  (amem_rd_out),
        .amem_addr_out(amem_addr_out),
        .amem_rdata_in(amem_rdata_in),
        .pe_data_out  (pe_data_out),
        .psum_row_0_in(p0),
        .psum_row_1_in(p1),
        .psum_row_2_in(p2),
`ifdef PE_SCHED_FULL_PSUM_EN
        .res_psum_out (res_psum_out),
`endif
        .res_valid_out(res_valid_out),
        .res_bits_out (res_bits_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_phase;

    logic [3:0]        wq [$];
    logic [ADDR_W-1:0] aq [$];
    logic [2:0]        rq [$];

    function automatic logic [DATA_W-1:0] amem_val(input logic [ADDR_W-1:0] a);
        return 27'h0500000 | DATA_W'(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference copy of the array's phase counter, reset by the same signal.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) tb_phase <= 0;
        else         tb_phase <= (tb_phase == FRAME_LEN - 1) ? 0 : tb_phase + 1;
    end

    // SRAM models: 1-cycle read latency.
    always @(posedge clk_in) begin
        wmem_rdata_in <= DATA_W'(wmem_addr_out) + DATA_W'(1);
        amem_rdata_in <= amem_val(amem_addr_out);
    end

    // Scoreboard monitor.
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (wmem_rd_out) begin
                if (wq.size() == 0) fail_now("wmem_unexpected_read");
                else check("wmem_addr", 32'(wmem_addr_out), 32'(wq.pop_front()));
            end
            if (amem_rd_out) begin
                if (aq.size() == 0) fail_now("amem_unexpected_read");
                else begin
                    check("amem_addr", 32'(amem_addr_out), 32'(aq.pop_front()));
                    check("amem_rd_phase_ok", 32'(tb_phase >= 8 && tb_phase <= 10), 32'd1);
                end
            end
            if (res_valid_out) begin
                if (rq.size() == 0) fail_now("res_unexpected");
                else begin
                    check("res_bits", 32'(res_bits_out), 32'(rq.pop_front()));
                    check("res_phase", 32'(tb_phase), 32'(CAP_PHASE + 3));
`ifdef PE_SCHED_FULL_PSUM_EN
                    check("res_psum_r0", 32'(res_psum_out[WIDTH-1:0]), 32'(p0));
                    check("res_psum_r2", 32'(res_psum_out[3*WIDTH-1:2*WIDTH]), 32'(p2));
`endif
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        check(name, {busy_out, done_out, wmem_rd_out, amem_rd_out, res_valid_out,
                     res_bits_out, 24'(pe_data_out != '0)}, 32'd0);
    endtask

    task automatic push_job(input int nf, input logic [ADDR_W-1:0] base, input logic [2:0] bits);
        for (int i = 0; i < N_WEIGHT; i++) wq.push_back(4'(i));
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < 3; i++) aq.push_back(base + ADDR_W'(3 * f + i));
            rq.push_back(bits);
        end
    endtask

    task automatic pulse_start(input int nf, input logic [ADDR_W-1:0] base);
        @(negedge clk_in);
        start_in      = 1'b1;
        num_frames_in = 16'(nf);
        act_base_in   = base;
        @(negedge clk_in);
        start_in      = 1'b0;
    endtask

    task automatic run_job(input int nf, input logic [ADDR_W-1:0] base, input logic [2:0] bits);
        int seen;
        logic got_done;
        logic [DATA_W-1:0] exp;
        push_job(nf, base, bits);
        pulse_start(nf, base);
        check("busy_after_start", 32'(busy_out), 32'd1);
        seen = -1;
        got_done = 1'b0;
        for (int c = 0; c < 12 * nf + 80; c++) begin
            if (done_out) begin
                got_done = 1'b1;
                break;
            end
            check("busy_during_job", 32'(busy_out), 32'd1);
            if (seen < 0 && pe_data_out != '0) begin
                seen = 0;
                check("run_start_phase", 32'(tb_phase), 32'd0);
            end
            if (seen >= 0 && seen < FRAME_LEN) begin
                exp = (seen < N_WEIGHT) ? DATA_W'(seen + 1)
                                        : amem_val(base + ADDR_W'(seen - N_WEIGHT));
                check("frame0_pe_data", 32'(pe_data_out), 32'(exp));
                seen++;
            end
            @(negedge clk_in);
        end
        if (!got_done) begin
            fail_now("done_timeout");
        end else begin
            check("busy_at_done", 32'(busy_out), 32'd1);
            check("done_phase", 32'(tb_phase), 32'd0);
        end
        @(negedge clk_in);
        check("done_one_cycle", 32'(done_out), 32'd0);
        check("busy_after_done", 32'(busy_out), 32'd0);
        check("scoreboard_empty", 32'(wq.size() + aq.size() + rq.size()), 32'd0);
    endtask

    initial begin
        // Reset and idle.
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_all_zero("reset_outputs");
        rst_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_in);
            check("idle_pe_data", 32'(pe_data_out), 32'd0);
        end

        // One frame, row signs {+4,-2,+1} -> 3'b010.
        p0 = WIDTH'(1); p1 = -WIDTH'(2); p2 = WIDTH'(4);
        run_job(1, 12'h010, 3'b010);

        // Four frames, psums -5, +3, -1 -> 3'b101.
        p0 = -WIDTH'(5); p1 = WIDTH'(3); p2 = -WIDTH'(1);
        run_job(4, 12'h100, 3'b101);

        // Zero-frame job: immediate done, no reads, never busy.
        pulse_start(0, 12'h040);
        check("zero_done", 32'(done_out), 32'd1);
        check("zero_busy", 32'(busy_out), 32'd0);
        @(negedge clk_in);
        check("zero_done_cleared", 32'(done_out), 32'd0);
        repeat (5) @(negedge clk_in);
        check("zero_busy_stays_low", 32'(busy_out), 32'd0);

        // Reset during RUN frame 2, then a clean job.
        push_job(4, 12'h200, 3'b101);
        pulse_start(4, 12'h200);
        begin
            int c;
            c = 0;
            while (!res_valid_out && c < 200) begin
                @(negedge clk_in);
                c++;
            end
            if (!res_valid_out) fail_now("abort_wait_timeout");
        end
        repeat (9) @(negedge clk_in);
        check("abort_frame2_phase", 32'(tb_phase), 32'd2);
        #2 rst_in = 1'b0;
        #1 check_all_zero("abort_outputs");
        wq.delete();
        aq.delete();
        rq.delete();
        repeat (2) @(negedge clk_in);
        check_all_zero("abort_held");
        rst_in = 1'b1;
        repeat (4) @(negedge clk_in);
        check("abort_no_done", 32'(done_out), 32'd0);
        run_job(2, 12'h300, 3'b101);

        // Address wrap.
        run_job(1, 12'hFFE, 3'b101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout (t=%0t)", $time);
        $fatal(1, "global timeout");
    end

endmodule
